add_sub_serial: RTL

Parametrised, multi-cycle unsigned adder/subtractor that processes its operands DIGIT bits per clock using a single DIGIT-wide full-adder slice. In subtract mode a negative result is returned as magnitude plus sign, using a second correction pass. The block is the sequential, width-generic successor to the team's 4-bit combinational add/sub with magnitude correction. It sits behind a valid/ready handshake so arithmetic datapaths can share one narrow adder across wide words.

---
 rtl/add_sub_serial.sv | 134 +++++++++++++
 1 files changed

// File: rtl/add_sub_serial.sv
// Digit-serial unsigned adder/subtractor behind a valid/ready handshake.
// Negative differences come back as magnitude plus sign via a second pass.
module add_sub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             neg,
  output logic             cout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    FIX,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic             r_m;
  logic             r_c;
  logic             r_co;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_s;
  logic             r_neg;
  logic             r_cout;

  logic [DIGIT-1:0] w_x;
  logic [DIGIT-1:0] w_y;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_q;
  logic             w_last;
  logic             w_fix;

  // One shared slice: ADD sums A+B digits, FIX negates q digit-by-digit.
  always_comb begin
    w_fix  = (r_state == FIX);
    w_x    = w_fix ? ~r_q[int'(r_k)*DIGIT +: DIGIT]
                   : r_a[int'(r_k)*DIGIT +: DIGIT];
    w_y    = w_fix ? '0 : r_b[int'(r_k)*DIGIT +: DIGIT];
    w_sum  = {1'b0, w_x} + {1'b0, w_y} + {{DIGIT{1'b0}}, r_c};
    w_q    = r_q;
    w_q[int'(r_k)*DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
    w_last = (r_k == KLAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_m     <= 1'b0;
      r_c     <= 1'b0;
      r_co    <= 1'b0;
      r_k     <= '0;
      r_s     <= '0;
      r_neg   <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{m}};
            r_m     <= m;
            r_k     <= '0;
            r_c     <= m;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_q <= w_q;
          r_c <= w_sum[DIGIT];
          r_k <= w_last ? '0 : r_k + 1'b1;
          if (w_last) begin
            r_co <= w_sum[DIGIT];
            if (r_m & ~w_sum[DIGIT]) begin
              r_c     <= 1'b1;
              r_state <= FIX;
            end else begin
              r_s     <= w_q;
              r_neg   <= 1'b0;
              r_cout  <= w_sum[DIGIT];
              r_state <= DONE;
            end
          end
        end
        FIX: begin
          r_q <= w_q;
          r_c <= w_sum[DIGIT];
          r_k <= w_last ? '0 : r_k + 1'b1;
          if (w_last) begin
            r_s     <= w_q;
            r_neg   <= 1'b1;
            r_cout  <= r_co;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) & ~rst;
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign neg       = r_neg;
  assign cout      = r_cout;

endmodule
